gpio_debounce: RTL and testbench

Input conditioning stage placed directly upstream of the TCB GPIO controller. It takes asynchronous GPIO pins and synchronizes them with a configurable flip-flop chain. Each bit is then debounced with a per-bit stability counter before driving the controller's `gpio_i`. The block also produces per-bit rise/fall pulses and sticky, maskable edge events that are OR-reduced into a single interrupt line.

---
 rtl/gpio_debounce_pkg.sv | 11 +
 rtl/gpio_debounce_bit.sv | 74 +++++++
 rtl/gpio_debounce.sv | 75 +++++++
 tb/tb_gpio_debounce.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg
//   Shared constants for the GPIO input conditioning slice: default widths
//   and the minimum synchronizer depth accepted by gpio_debounce.
package gpio_debounce_pkg;

    localparam int unsigned GW_DEF  = 32;  // GPIO width, matches the controller
    localparam int unsigned CDC_DEF = 2;   // synchronizer depth
    localparam int unsigned CDC_MIN = 2;   // shallowest chain that still resolves metastability
    localparam int unsigned CW_DEF  = 8;   // debounce counter / threshold width

endpackage : gpio_debounce_pkg

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit
//   One GPIO bit: CDC-deep synchronizer, stability counter, debounced level
//   and one-cycle rise/fall pulses.
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   pin     asynchronous pad input
//   thr     debounce threshold (N requires N+1 consecutive differing samples)
//   lvl     debounced level
//   rise    registered 0->1 pulse
//   fall    registered 1->0 pulse
//   rise_n  value rise takes on the next edge (feeds the event register)
//   fall_n  value fall takes on the next edge (feeds the event register)
module gpio_debounce_bit
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned CDC = CDC_DEF,
    parameter int unsigned CW  = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pin,
    input  logic [CW-1:0] thr,
    output logic          lvl,
    output logic          rise,
    output logic          fall,
    output logic          rise_n,
    output logic          fall_n
);

    logic [CDC-1:0] sync;
    logic           s;
    logic [CW-1:0]  c;
    logic [CW-1:0]  c_n;
    logic           lvl_n;

    assign s = sync[CDC-1];

    // '>=' lets a threshold lowered mid-count accept on the next differing
    // sample; c is capped at thr so it can never wrap.
    always_comb begin
        lvl_n  = lvl;
        c_n    = c;
        rise_n = 1'b0;
        fall_n = 1'b0;
        if (s == lvl) begin
            c_n = '0;
        end else if (c >= thr) begin
            lvl_n  = s;
            c_n    = '0;
            rise_n = s;
            fall_n = ~s;
        end else begin
            c_n = c + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            lvl  <= 1'b0;
            c    <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[CDC-2:0], pin};
            lvl  <= lvl_n;
            c    <= c_n;
            rise <= rise_n;
            fall <= fall_n;
        end
    end

endmodule : gpio_debounce_bit

// File: rtl/gpio_debounce.sv
// gpio_debounce
//   Input conditioning in front of the TCB GPIO controller: per-bit
//   synchronize + debounce, rise/fall pulses, sticky maskable edge events
//   and a registered OR-reduced interrupt.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   pin_i    asynchronous pad inputs
//   cfg_thr  debounce threshold shared by all bits
//   cfg_rie  per-bit rising-edge event enable
//   cfg_fie  per-bit falling-edge event enable
//   evt_clr  write-one-to-clear for evt
//   gpio_i   debounced levels to the controller
//   rise     one-cycle 0->1 pulses
//   fall     one-cycle 1->0 pulses
//   evt      sticky edge events
//   irq      |evt, registered
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned GW  = GW_DEF,
    parameter int unsigned CDC = CDC_DEF,
    parameter int unsigned CW  = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [GW-1:0] pin_i,
    input  logic [CW-1:0] cfg_thr,
    input  logic [GW-1:0] cfg_rie,
    input  logic [GW-1:0] cfg_fie,
    input  logic [GW-1:0] evt_clr,
    output logic [GW-1:0] gpio_i,
    output logic [GW-1:0] rise,
    output logic [GW-1:0] fall,
    output logic [GW-1:0] evt,
    output logic          irq
);

    if (CDC < CDC_MIN) begin : g_cdc_check
        $error("gpio_debounce: CDC must be at least %0d", CDC_MIN);
    end

    logic [GW-1:0] rise_n;
    logic [GW-1:0] fall_n;

    for (genvar i = 0; i < GW; i++) begin : g_bit
        gpio_debounce_bit #(
            .CDC (CDC),
            .CW  (CW)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .pin    (pin_i[i]),
            .thr    (cfg_thr),
            .lvl    (gpio_i[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .rise_n (rise_n[i]),
            .fall_n (fall_n[i])
        );
    end

    // Clear is applied before the new edges are OR-ed in, so a set on the
    // same edge as a clear survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt <= '0;
            irq <= 1'b0;
        end else begin
            evt <= (evt & ~evt_clr) | (rise_n & cfg_rie) | (fall_n & cfg_fie);
            irq <= |evt;
        end
    end

endmodule : gpio_debounce

// File: tb/tb_gpio_debounce.sv
module tb_gpio_debounce;

  localparam int GW = 32;
  localparam int CW = 8;

  localparam int SIG_GPIO = 0;
  localparam int SIG_RISE = 1;
  localparam int SIG_FALL = 2;
  localparam int SIG_EVT  = 3;
  localparam int SIG_IRQ  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [GW-1:0] pin_i;
  logic [CW-1:0] cfg_thr;
  logic [GW-1:0] cfg_rie;
  logic [GW-1:0] cfg_fie;
  logic [GW-1:0] evt_clr;
  logic [GW-1:0] gpio_i;
  logic [GW-1:0] rise;
  logic [GW-1:0] fall;
  logic [GW-1:0] evt;
  logic          irq;

  gpio_debounce #(
    .GW  (GW),
    .CDC (2),
    .CW  (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (pin_i),
    .cfg_thr (cfg_thr),
    .cfg_rie (cfg_rie),
    .cfg_fie (cfg_fie),
    .evt_clr (evt_clr),
    .gpio_i  (gpio_i),
    .rise    (rise),
    .fall    (fall),
    .evt     (evt),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] mask;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] sigval(input int sig);
    case (sig)
      SIG_GPIO: return gpio_i;
      SIG_RISE: return rise;
      SIG_FALL: return fall;
      SIG_EVT:  return evt;
      default:  return {31'd0, irq};
    endcase
  endfunction

  // Monitor: compares every scoreboard entry due on this cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        act = sigval(sb[i].sig) & sb[i].mask;
        checks++;
        if (sb[i].at < cyc || act !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %h expected %h",
                   sb[i].name, sb[i].at, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  // Inputs change 2 time units after a rising edge; "edge n" is the n-th
  // rising edge after the change.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic exp_push(input int dc, input int sig, input logic [31:0] mask,
                          input logic [31:0] val, input string name);
    exp_t e;
    e.at   = cyc + dc;
    e.sig  = sig;
    e.mask = mask;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_all_zero(input string name);
    exp_push(0, SIG_GPIO, '1, '0, {name, "_gpio"});
    exp_push(0, SIG_RISE, '1, '0, {name, "_rise"});
    exp_push(0, SIG_FALL, '1, '0, {name, "_fall"});
    exp_push(0, SIG_EVT,  '1, '0, {name, "_evt"});
    exp_push(0, SIG_IRQ,  '1, '0, {name, "_irq"});
  endtask

  initial begin
    rst     = 1'b0;
    pin_i   = '0;
    cfg_thr = 8'd3;
    cfg_rie = '0;
    cfg_fie = '0;
    evt_clr = '0;
    tick(2);
    exp_all_zero("reset");

    checks++;
    if (gpio_i !== '0) begin
      errors++;
      $display("FAIL direct_reset_gpio: got %h", gpio_i);
    end
    checks++;
    if (rise !== '0) begin
      errors++;
      $display("FAIL direct_reset_rise: got %h", rise);
    end
    checks++;
    if (fall !== '0) begin
      errors++;
      $display("FAIL direct_reset_fall: got %h", fall);
    end
    checks++;
    if (evt !== '0) begin
      errors++;
      $display("FAIL direct_reset_evt: got %h", evt);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL direct_reset_irq: got %b", irq);
    end

    tick(1);
    rst = 1'b1;
    tick(2);

    // Basic latency: CDC=2, thr=3 -> edge 6
    pin_i[0] = 1'b1;
    exp_push(5, SIG_GPIO, 32'h1, 32'h0, "lat_gpio_e5");
    exp_push(6, SIG_GPIO, 32'h1, 32'h1, "lat_gpio_e6");
    exp_push(5, SIG_RISE, 32'h1, 32'h0, "lat_rise_e5");
    exp_push(6, SIG_RISE, 32'h1, 32'h1, "lat_rise_e6");
    exp_push(7, SIG_RISE, 32'h1, 32'h0, "lat_rise_e7");
    exp_push(6, SIG_FALL, '1, '0, "lat_fall_e6");
    exp_push(7, SIG_FALL, '1, '0, "lat_fall_e7");
    tick(10);

    // Glitch rejection: two 3-cycle pulses on bit 5, neither accepted
    pin_i[5] = 1'b1;
    exp_push(4, SIG_GPIO, 32'h20, 32'h0, "glitch_gpio_e4");
    exp_push(6, SIG_GPIO, 32'h20, 32'h0, "glitch_gpio_e6");
    exp_push(8, SIG_GPIO, 32'h20, 32'h0, "glitch_gpio_e8");
    exp_push(5, SIG_RISE, 32'h20, 32'h0, "glitch_rise_e5");
    exp_push(6, SIG_RISE, 32'h20, 32'h0, "glitch_rise_e6");
    exp_push(7, SIG_RISE, 32'h20, 32'h0, "glitch_rise_e7");
    tick(3);
    pin_i[5] = 1'b0;
    tick(2);
    pin_i[5] = 1'b1;
    exp_push(6, SIG_GPIO, 32'h20, 32'h0, "glitch2_gpio_e6");
    exp_push(8, SIG_GPIO, 32'h20, 32'h0, "glitch2_gpio_e8");
    exp_push(6, SIG_RISE, 32'h20, 32'h0, "glitch2_rise_e6");
    tick(3);
    pin_i[5] = 1'b0;
    tick(10);

    // Boundary: a 4-cycle pulse is accepted, then its fall
    pin_i[5] = 1'b1;
    exp_push(5, SIG_GPIO, 32'h20, 32'h00, "accept4_gpio_e5");
    exp_push(6, SIG_GPIO, 32'h20, 32'h20, "accept4_gpio_e6");
    tick(4);
    pin_i[5] = 1'b0;
    exp_push(5, SIG_FALL, 32'h20, 32'h00, "accept4_fall_e5");
    exp_push(6, SIG_FALL, 32'h20, 32'h20, "accept4_fall_e6");
    exp_push(6, SIG_GPIO, 32'h20, 32'h00, "accept4_gpio_low");
    tick(10);

    // Events and interrupt
    cfg_rie = 32'h1;
    cfg_fie = 32'h2;
    pin_i[0] = 1'b0;
    exp_push(6, SIG_FALL, 32'h1, 32'h1, "evt_fall0");
    exp_push(6, SIG_EVT,  '1, '0, "evt_fall0_masked");
    exp_push(7, SIG_EVT,  '1, '0, "evt_fall0_masked_e7");
    tick(10);
    pin_i[1:0] = 2'b11;
    exp_push(6, SIG_RISE, 32'h3, 32'h3, "evt_rise01");
    exp_push(5, SIG_EVT,  '1, 32'h0, "evt_e5");
    exp_push(6, SIG_EVT,  '1, 32'h1, "evt_e6");
    exp_push(6, SIG_IRQ,  '1, 32'h0, "irq_e6");
    exp_push(7, SIG_IRQ,  '1, 32'h1, "irq_e7");
    tick(10);
    pin_i[1] = 1'b0;
    exp_push(6, SIG_EVT, '1, 32'h3, "evt_fall1");
    exp_push(7, SIG_IRQ, '1, 32'h1, "irq_fall1");
    tick(10);
    evt_clr = 32'h3;
    exp_push(1, SIG_EVT, '1, 32'h0, "evt_clr");
    exp_push(1, SIG_IRQ, '1, 32'h1, "irq_clr_e1");
    exp_push(2, SIG_IRQ, '1, 32'h0, "irq_clr_e2");
    tick(1);
    evt_clr = '0;
    tick(5);

    // Set wins over clear on the same edge
    pin_i[0] = 1'b0;
    tick(10);
    pin_i[0] = 1'b1;
    exp_push(6, SIG_RISE, 32'h1, 32'h1, "setwin_rise");
    exp_push(6, SIG_EVT,  32'h1, 32'h1, "setwin_evt_e6");
    exp_push(8, SIG_EVT,  32'h1, 32'h1, "setwin_evt_e8");
    tick(5);
    evt_clr = 32'h1;
    tick(1);
    evt_clr = '0;
    tick(5);
    evt_clr = 32'h1;
    exp_push(1, SIG_EVT, 32'h1, 32'h0, "setwin_cleared");
    tick(1);
    evt_clr = '0;
    tick(3);

    // Zero threshold: 1-cycle toggle propagates with latency CDC+1
    cfg_thr = 8'd0;
    pin_i[2] = 1'b1;
    exp_push(2, SIG_GPIO, 32'h4, 32'h0, "thr0_gpio_e2");
    exp_push(3, SIG_GPIO, 32'h4, 32'h4, "thr0_gpio_e3");
    exp_push(4, SIG_GPIO, 32'h4, 32'h0, "thr0_gpio_e4");
    exp_push(3, SIG_RISE, 32'h4, 32'h4, "thr0_rise_e3");
    exp_push(4, SIG_RISE, 32'h4, 32'h0, "thr0_rise_e4");
    exp_push(3, SIG_FALL, 32'h4, 32'h0, "thr0_fall_e3");
    exp_push(4, SIG_FALL, 32'h4, 32'h4, "thr0_fall_e4");
    exp_push(5, SIG_FALL, 32'h4, 32'h0, "thr0_fall_e5");
    tick(1);
    pin_i[2] = 1'b0;
    tick(8);

    // Threshold decrease: c reaches 50 at edge 52, thr drops to 10
    cfg_thr = 8'd200;
    pin_i[3] = 1'b1;
    exp_push(52, SIG_GPIO, 32'h8, 32'h0, "thrdec_gpio_e52");
    exp_push(53, SIG_GPIO, 32'h8, 32'h8, "thrdec_gpio_e53");
    exp_push(52, SIG_RISE, 32'h8, 32'h0, "thrdec_rise_e52");
    exp_push(53, SIG_RISE, 32'h8, 32'h8, "thrdec_rise_e53");
    exp_push(54, SIG_RISE, 32'h8, 32'h0, "thrdec_rise_e54");
    tick(52);
    cfg_thr = 8'd10;
    tick(5);

    // Reset mid-count, release with all pins high
    cfg_thr = 8'd3;
    cfg_rie = '1;
    cfg_fie = '0;
    pin_i   = '1;
    tick(4);
    rst = 1'b0;
    exp_all_zero("midrst");
    #1;

    checks++;
    if (gpio_i !== '0) begin
      errors++;
      $display("FAIL direct_midrst_gpio: got %h", gpio_i);
    end
    checks++;
    if (rise !== '0) begin
      errors++;
      $display("FAIL direct_midrst_rise: got %h", rise);
    end
    checks++;
    if (fall !== '0) begin
      errors++;
      $display("FAIL direct_midrst_fall: got %h", fall);
    end
    checks++;
    if (evt !== '0) begin
      errors++;
      $display("FAIL direct_midrst_evt: got %h", evt);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL direct_midrst_irq: got %b", irq);
    end

    tick(2);
    rst = 1'b1;
    exp_push(5, SIG_RISE, '1, 32'h0,         "rel_rise_e5");
    exp_push(6, SIG_RISE, '1, 32'hFFFF_FFFF, "rel_rise_e6");
    exp_push(7, SIG_RISE, '1, 32'h0,         "rel_rise_e7");
    exp_push(8, SIG_RISE, '1, 32'h0,         "rel_rise_e8");
    exp_push(6, SIG_GPIO, '1, 32'hFFFF_FFFF, "rel_gpio_e6");
    exp_push(6, SIG_EVT,  '1, 32'hFFFF_FFFF, "rel_evt_e6");
    exp_push(6, SIG_IRQ,  '1, 32'h0,         "rel_irq_e6");
    exp_push(7, SIG_IRQ,  '1, 32'h1,         "rel_irq_e7");
    tick(10);

    for (int unsigned n = 0; n < 100 && sb.size() > 0; n++) tick(1);
    for (int unsigned i = 0; i < sb.size(); i++) begin
      errors++;
      $display("FAIL %s: never checked, expected %h", sb[i].name, sb[i].val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gpio_debounce
